// File: rtl/isl58x_bus_rx.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : isl58x_bus_rx
// Purpose  : Receive side of the ISL58315 parallel laser-driver interface.
//            Synchronises D/CLK/RTZ/LOWP/CE into clk_i, recovers words on
//            CLK edges and presents them on a first-word-fall-through
//            valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module isl58x_bus_rx #(
  parameter int DW          = 15,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DW-1:0]    isl58x_D_i,
  input  logic             isl58x_CLK_i,
  input  logic             isl58x_RTZ_i,
  input  logic             isl58x_LOWP_i,
  input  logic             isl58x_CE_i,
  input  logic [1:0]       isl58x_DATA_MODE_i,
  output logic [DW+1:0]    m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             ovf_o,
  input  logic             ovf_clr_i,
  output logic             mode_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] sample_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DW + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    ERR    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]         ce_sync;
  logic [SYNC_STAGES-1:0]         clk_sync;
  logic [SYNC_STAGES-1:0]         rtz_sync;
  logic [SYNC_STAGES-1:0]         lowp_sync;
  logic [SYNC_STAGES-1:0][1:0]    mode_sync;
  logic [SYNC_STAGES-1:0][DW-1:0] d_sync;

  // Word and strobe one stage past the synchronisers, kept aligned so the
  // data is taken at the same depth as the CLK sample showing the new level.
  logic          clk_q;
  logic          clk_qq;
  logic [WW-1:0] word_q;

  state_t state;
  logic   mode_both;

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [WW-1:0] last_data;

  logic ce_s;
  logic rise;
  logic fall;
  logic capture;
  logic empty;
  logic full;
  logic rd_en;
  logic wr_en;
  logic drop;

  assign ce_s    = ce_sync[SYNC_STAGES-1];
  assign rise    = clk_q & ~clk_qq;
  assign fall    = ~clk_q & clk_qq;
  assign capture = (state == ACTIVE) & ce_s & (rise | (mode_both & fall));

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write
  assign rd_en = ~empty & m_ready_i;
  assign wr_en = capture & (~full | rd_en);
  assign drop  = capture & full & ~rd_en;

  assign m_valid_o = ~empty;
  assign m_data_o  = empty ? last_data : mem[rd_ptr[AW-1:0]];

  // Synchroniser chains for every interface pin plus the alignment stage
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ce_sync   <= '0;
      clk_sync  <= '0;
      rtz_sync  <= '0;
      lowp_sync <= '0;
      mode_sync <= '0;
      d_sync    <= '0;
      clk_q     <= 1'b0;
      clk_qq    <= 1'b0;
      word_q    <= '0;
    end else begin
      ce_sync   <= {ce_sync[SYNC_STAGES-2:0], isl58x_CE_i};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], isl58x_CLK_i};
      rtz_sync  <= {rtz_sync[SYNC_STAGES-2:0], isl58x_RTZ_i};
      lowp_sync <= {lowp_sync[SYNC_STAGES-2:0], isl58x_LOWP_i};
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], isl58x_DATA_MODE_i};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], isl58x_D_i};
      clk_q     <= clk_sync[SYNC_STAGES-1];
      clk_qq    <= clk_q;
      word_q    <= {rtz_sync[SYNC_STAGES-1], lowp_sync[SYNC_STAGES-1],
                    d_sync[SYNC_STAGES-1]};
    end
  end

  // Capture state machine; CE low wins over every other transition
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      mode_both  <= 1'b0;
      busy_o     <= 1'b0;
      mode_err_o <= 1'b0;
    end else if (!ce_s) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      mode_err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mode_both <= mode_sync[SYNC_STAGES-1][0];
          if (mode_sync[SYNC_STAGES-1][1]) begin
            state      <= ERR;
            mode_err_o <= 1'b1;
          end else begin
            state  <= ARM;
            busy_o <= 1'b1;
          end
        end
        // A CLK already high at CE rise must fall before anything is captured
        ARM: begin
          if (!clk_q) state <= ACTIVE;
        end
        default: state <= state;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= word_q;
  end

  // Pointers, held output word, overflow flag and write counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_data    <= '0;
      ovf_o        <= 1'b0;
      sample_cnt_o <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr       <= wr_ptr + (AW+1)'(1);
        sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      end
      if (rd_en) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        last_data <= mem[rd_ptr[AW-1:0]];
      end
      if (drop) ovf_o <= 1'b1;
      else if (ovf_clr_i) ovf_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isl58x_bus_rx.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_isl58x_bus_rx
// Purpose  : Self-checking bench for isl58x_bus_rx. Pin-level stimulus with
//            random data; a queue of expected words is compared at every
//            stream handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_isl58x_bus_rx;

  localparam int DW    = 15;
  localparam int DEPTH = 16;
  localparam int SS    = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    pin_d;
  logic             pin_clk;
  logic             pin_rtz;
  logic             pin_lowp;
  logic             pin_ce;
  logic [1:0]       pin_mode;
  logic [DW+1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             ovf;
  logic             ovf_clr;
  logic             mode_err;
  logic             busy;
  logic [CNT_W-1:0] sample_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW+1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_ovf;
  bit               rand_ready;

  isl58x_bus_rx #(
    .DW(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .isl58x_D_i(pin_d), .isl58x_CLK_i(pin_clk), .isl58x_RTZ_i(pin_rtz),
    .isl58x_LOWP_i(pin_lowp), .isl58x_CE_i(pin_ce), .isl58x_DATA_MODE_i(pin_mode),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr), .mode_err_o(mode_err), .busy_o(busy),
    .sample_cnt_o(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after each rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Reference model: a capturing edge stores the pin word if there is room
  task automatic model_capture();
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back({pin_rtz, pin_lowp, pin_d});
      exp_cnt++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic set_word(input logic [DW-1:0] d, input logic r, input logic l);
    pin_d = d; pin_rtz = r; pin_lowp = l;
    cyc(2);
  endtask

  task automatic strobe(input logic lvl, input bit expect_cap);
    pin_clk = lvl;
    if (expect_cap) model_capture();
    cyc(4);
  endtask

  task automatic rise_word(input logic [DW-1:0] d, input bit expect_cap);
    set_word(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    strobe(1'b1, expect_cap);
    strobe(1'b0, 1'b0);
  endtask

  task automatic start_ce(input logic [1:0] mode);
    pin_ce = 1'b0;
    cyc(6);
    pin_mode = mode;
    pin_ce   = 1'b1;
    cyc(8);
  endtask

  task automatic check_drained(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 60) begin
      cyc(1);
      n++;
    end
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_valid_low"}, 64'(m_valid), 64'd0);
  endtask

  // Stream monitor: compares every accepted word and checks stall stability
  logic [DW+1:0] held;
  bit            holding = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 0;
    end else begin
      if (holding) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(held));
      end
      holding = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 64'(exp_q.size()), 64'd1);
        else chk("word", 64'(m_data), 64'(exp_q.pop_front()));
      end else if (m_valid) begin
        holding = 1;
        held    = m_data;
      end
    end
  end

  initial begin
    int lat;
    bit found;
    logic mode_r;

    rst_n = 1'b0; pin_d = '0; pin_clk = 1'b0; pin_rtz = 1'b0; pin_lowp = 1'b0;
    pin_ce = 1'b0; pin_mode = 2'd0; m_ready = 1'b0; ovf_clr = 1'b0;
    exp_cnt = '0; exp_ovf = 1'b0; rand_ready = 0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_data", 64'(m_data), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_mode_err", 64'(mode_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cnt", 64'(sample_cnt), 64'd0);

    // Mode 0, eight rising edges, D = 1..8, consumer always ready
    m_ready = 1'b1;
    start_ce(2'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    set_word(DW'(1), 1'b0, 1'b1);
    pin_clk = 1'b1;
    model_capture();
    lat = -1; found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!found && m_valid) begin lat = i; found = 1; end
      @(posedge clk);
      #2;
    end
    chk("t1_latency", 64'(lat), 64'(SS + 2));
    strobe(1'b0, 1'b0);
    for (int i = 2; i <= 8; i++) rise_word(DW'(i), 1'b1);
    check_drained("t1");
    chk("t1_cnt", 64'(sample_cnt), 64'd8);

    // Mode 1, four CLK periods, data changes every half period
    start_ce(2'd1);
    for (int i = 0; i < 4; i++) begin
      set_word(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      strobe(1'b1, 1'b1);
      set_word(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      strobe(1'b0, 1'b1);
    end
    check_drained("t2");
    chk("t2_cnt", 64'(sample_cnt), 64'(exp_cnt));

    // Overflow: consumer stalled, 20 edges into a 16-deep FIFO
    start_ce(2'd0);
    m_ready = 1'b0;
    for (int i = 1; i <= 20; i++) rise_word(DW'(i), 1'b1);
    chk("t3_ovf_set", 64'(ovf), 64'(exp_ovf));
    chk("t3_cnt", 64'(sample_cnt), 64'(exp_cnt));
    chk("t3_queue_full", 64'(exp_q.size()), 64'(DEPTH));
    m_ready = 1'b1;
    check_drained("t3");
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    cyc(1);
    chk("t3_ovf_clear", 64'(ovf), 64'(exp_ovf));

    // CE rises while CLK is already high: that level is not a word
    pin_ce = 1'b0;
    cyc(6);
    pin_clk = 1'b1;
    cyc(6);
    pin_mode = 2'd0;
    pin_ce = 1'b1;
    cyc(12);
    chk("t4_armed_busy", 64'(busy), 64'd1);
    chk("t4_no_word", 64'(m_valid), 64'd0);
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rise_word(DW'($urandom), 1'b1);
    check_drained("t4");
    pin_ce = 1'b0;
    cyc(SS);
    chk("t4_busy_before", 64'(busy), 64'd1);
    cyc(1);
    chk("t4_busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < 2; i++) rise_word(DW'($urandom), 1'b0);
    cyc(8);
    chk("t4_cnt_frozen", 64'(sample_cnt), 64'(exp_cnt));
    check_drained("t4b");

    // Illegal data mode latched at CE rise
    start_ce(2'd2);
    chk("t5_mode_err", 64'(mode_err), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 2; i++) rise_word(DW'($urandom), 1'b0);
    pin_mode = 2'd0;
    cyc(8);
    chk("t5_still_err", 64'(mode_err), 64'd1);
    chk("t5_cnt", 64'(sample_cnt), 64'(exp_cnt));
    start_ce(2'd0);
    chk("t5_err_cleared", 64'(mode_err), 64'd0);
    for (int i = 0; i < 2; i++) rise_word(DW'($urandom), 1'b1);
    check_drained("t5");
    chk("t5_cnt_after", 64'(sample_cnt), 64'(exp_cnt));

    // Random mode with a randomly stalling consumer
    mode_r = 1'($urandom_range(0, 1));
    start_ce({1'b0, mode_r});
    rand_ready = 1;
    for (int i = 0; i < 6; i++) begin
      set_word(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      strobe(1'b1, 1'b1);
      set_word(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      strobe(1'b0, mode_r);
    end
    rand_ready = 0;
    m_ready = 1'b1;
    check_drained("t7");
    chk("t7_cnt", 64'(sample_cnt), 64'(exp_cnt));
    chk("t7_ovf", 64'(ovf), 64'd0);

    // Reset with words buffered and CLK high
    start_ce(2'd0);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) rise_word(DW'($urandom), 1'b1);
    set_word(DW'($urandom), 1'b1, 1'b1);
    strobe(1'b1, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    exp_ovf = 1'b0;
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_cnt", 64'(sample_cnt), 64'd0);
    chk("t6_ovf", 64'(ovf), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    m_ready = 1'b1;
    cyc(12);
    chk("t6_high_not_captured", 64'(m_valid), 64'd0);
    strobe(1'b0, 1'b0);
    rise_word(DW'($urandom), 1'b1);
    check_drained("t6");
    chk("t6_cnt_after", 64'(sample_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
